instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage that drives the program ROM address bus and consumes its combinational instruction word.
- Keeps the program counter and a small prefetch FIFO of {pc, instruction} pairs.
- Presents instructions to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump/trap target) that flushes the prefetch FIFO and restarts fetch.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset. Must be 4-byte aligned.
- DEPTH, 2, prefetch FIFO entries (power of two, 2..8).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rom_addr  out  32  byte address to the program ROM; always equals the internal fetch PC.
- rom_data  in  32  instruction word from the ROM, combinational from rom_addr.
- fetch_en  in  1  when 0, no new fetches are pushed; the FIFO still drains.
- redirect  in  1  single-cycle redirect request.
- redirect_pc  in  32  redirect target byte address.
- misaligned  out  1  registered one-cycle pulse: the last accepted redirect_pc had a nonzero [1:0].
- if_valid  out  1  the FIFO head holds a valid instruction.
- if_ready  in  1  decode accepts the head this cycle.
- if_instr  out  32  instruction at the FIFO head.
- if_pc  out  32  byte address of if_instr.

Behaviour:
- Reset (async, rst_n=0):
  - fetch PC = RESET_VECTOR; count = 0; read and write pointers = 0; misaligned = 0.
  - if_valid = 0. if_instr and if_pc read the head slot, and every slot is cleared to 0 on reset.
  - Reset asserted mid-operation discards all buffered entries immediately.
- Per-cycle signals:
  - pop = if_valid & if_ready.
  - push = ~redirect & fetch_en & (count < DEPTH | pop).
- Priority, highest first: redirect, then simultaneous push/pop, then a single push or pop.
- Redirect (redirect=1 at a clock edge):
  - count, rd_ptr and wr_ptr go to 0. A concurrent pop is discarded: decode must treat the head as squashed.
  - No push that cycle.
  - PC <= {redirect_pc[31:2], 2'b00}.
  - misaligned <= |redirect_pc[1:0] for one cycle.
- Push:
  - FIFO[wr_ptr] <= {PC, rom_data}; wr_ptr and PC advance (PC += 4).
  - PC wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0.
- Pop: rd_ptr advances.
- count update: +1 on push only, -1 on pop only, unchanged on both.
  - Push while full is allowed only when pop is in the same cycle (the slot is freed that edge).
  - count never exceeds DEPTH and never underflows.
- Outputs:
  - if_valid = (count != 0).
  - if_instr and if_pc come directly from FIFO[rd_ptr] registers, with no combinational path from rom_data.
  - Handshake: once if_valid=1, if_instr and if_pc hold stable until popped or flushed by redirect.
- Latency:
  - First instruction: the first edge after reset release pushes RESET_VECTOR; if_valid=1 after that edge.
  - Redirect: edge N flushes and loads the target, with if_valid=0 for one cycle; edge N+1 pushes the target.
  - Steady state with if_ready=1 and fetch_en=1: one instruction per cycle, no bubbles.
- fetch_en=0: PC frozen, no pushes; the FIFO drains normally; redirect still honoured.

Test Plan:
- Reset release with ROM mem[k]=32'h1000_0000+k, if_ready=1, fetch_en=1 -> if_pc 0,4,8,12 on consecutive cycles, if_instr 32'h1000_0000..32'h1000_0003, if_valid stays 1 after the first edge.
- if_ready=0 for 5 cycles after reset -> count saturates at DEPTH=2, rom_addr stops at 8; holding if_instr=32'h1000_0000 and if_pc=0; on if_ready=1, pcs 0,4,8 follow without loss or duplication.
- Redirect to 32'h40 while the FIFO is full and if_ready=1 -> next cycle if_valid=0, rom_addr=32'h40; following cycle if_pc=32'h40, if_instr=mem[16]; no stale pc 4/8 appears.
- Redirect to 32'h42 -> misaligned pulses 1 for exactly one cycle; fetch resumes at 32'h40.
- Redirect to 32'hFFFF_FFF8 with ROM returning addr-derived words -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert rst_n=0 asynchronously mid-stream (between edges) with count=2 -> if_valid drops immediately; after release, fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the program ROM address and buffers {pc, instruction} pairs
// in a small prefetch FIFO. Decode reads the FIFO over a valid/ready handshake.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned DEPTH        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        misaligned,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          misaligned_q, misaligned_d;

    logic [31:0]   slot_pc_q    [DEPTH];
    logic [31:0]   slot_instr_q [DEPTH];

    logic          push;
    logic          pop;

    assign pop  = if_valid & if_ready;
    // A full FIFO may still accept a push when the head leaves on the same edge.
    assign push = ~redirect & fetch_en & ((count_q < DEPTH_C) | pop);

    always_comb begin
        pc_d         = pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        misaligned_d = 1'b0;

        if (redirect) begin
            // A pop in the same cycle is squashed along with everything else.
            pc_d         = {redirect_pc[31:2], 2'b00};
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            misaligned_d = |redirect_pc[1:0];
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_VECTOR;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_pc_q[i]    <= '0;
                slot_instr_q[i] <= '0;
            end
        end else if (push) begin
            slot_pc_q[wr_ptr_q]    <= pc_q;
            slot_instr_q[wr_ptr_q] <= rom_data;
        end
    end

    // Head is taken straight from slot registers so decode never sees rom_data combinationally.
    assign rom_addr   = pc_q;
    assign misaligned = misaligned_q;
    assign if_valid   = (count_q != '0);
    assign if_instr   = slot_instr_q[rd_ptr_q];
    assign if_pc      = slot_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: ROM word at byte address a is 32'h1000_0000 + a/4.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misaligned;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .DEPTH        (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .misaligned  (misaligned),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc)
    );

    assign rom_data = 32'h1000_0000 + {2'b00, rom_addr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
        chk({tag, "_pc"}, if_pc, pc);
        chk({tag, "_instr"}, if_instr, instr);
    endtask

    initial begin
        rst_n       = 1'b0;
        fetch_en    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        if_ready    = 1'b1;
        #1;
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_addr", rom_addr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);
        #11 rst_n = 1'b1;

        // Streaming from reset, decode always ready
        tick(); chk_head("s0", 32'h0, 32'h1000_0000);
        tick(); chk_head("s1", 32'h4, 32'h1000_0001);
        tick(); chk_head("s2", 32'h8, 32'h1000_0002);
        tick(); chk_head("s3", 32'hC, 32'h1000_0003);
        chk("s3_addr", rom_addr, 32'h10);

        // Backpressure after reset: FIFO fills to 2 and head holds
        rst_n = 1'b0; if_ready = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_head("bp_hold", 32'h0, 32'h1000_0000);
        end
        chk("bp_addr", rom_addr, 32'h8);
        if_ready = 1'b1;
        tick(); chk_head("bp_d1", 32'h4, 32'h1000_0001);
        tick(); chk_head("bp_d2", 32'h8, 32'h1000_0002);
        tick(); chk_head("bp_d3", 32'hC, 32'h1000_0003);

        // Redirect to 0x40 while full and ready
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        chk("rd40_valid", {31'd0, if_valid}, 32'd0);
        chk("rd40_addr", rom_addr, 32'h40);
        chk("rd40_mis", {31'd0, misaligned}, 32'd0);
        tick(); chk_head("rd40_h0", 32'h40, 32'h1000_0010);
        tick(); chk_head("rd40_h1", 32'h44, 32'h1000_0011);

        // Misaligned redirect
        redirect = 1'b1; redirect_pc = 32'h42;
        tick();
        redirect = 1'b0;
        chk("mis_pulse", {31'd0, misaligned}, 32'd1);
        chk("mis_addr", rom_addr, 32'h40);
        chk("mis_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("mis_clear", {31'd0, misaligned}, 32'd0);
        chk_head("mis_h0", 32'h40, 32'h1000_0010);

        // PC wrap at top of address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        tick(); chk_head("wr0", 32'hFFFF_FFF8, 32'h4FFF_FFFE);
        tick(); chk_head("wr1", 32'hFFFF_FFFC, 32'h4FFF_FFFF);
        tick(); chk_head("wr2", 32'h0000_0000, 32'h1000_0000);
        tick(); chk_head("wr3", 32'h0000_0004, 32'h1000_0001);

        // fetch_en=0: drain, PC frozen
        fetch_en = 1'b0;
        tick();
        chk("fe_valid", {31'd0, if_valid}, 32'd0);
        chk("fe_addr", rom_addr, 32'h8);
        tick();
        chk("fe_addr2", rom_addr, 32'h8);
        fetch_en = 1'b1;

        // Fill to 2 then async reset between edges
        if_ready = 1'b0;
        tick(); tick();
        chk_head("ar_full", 32'h8, 32'h1000_0002);
        chk("ar_addr", rom_addr, 32'h10);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, if_valid}, 32'd0);
        chk("ar_rst_addr", rom_addr, 32'h0);
        chk("ar_rst_pc", if_pc, 32'h0);
        #2 rst_n = 1'b1; if_ready = 1'b1;
        tick(); chk_head("ar_h0", 32'h0, 32'h1000_0000);
        tick(); chk_head("ar_h1", 32'h4, 32'h1000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
